// File: rtl/edge_phase_tracker.sv
// Clock-recovery phase detector: measures where each rxd edge lands against the
// local bit boundary and requests sampler rate corrections.
module edge_phase_tracker #(
    parameter int SAMPLE_FREQ  = 16,
    parameter int MAX_DIFF     = 5,
    parameter int DEADBAND     = 1,
    parameter int HOLDOFF_BITS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enb,
    input  logic                           rxd,
    input  logic                           lock_en,
    output logic                           speed_up,
    output logic                           slow_down,
    output logic [4:0]                     diff_amt,
    output logic [$clog2(SAMPLE_FREQ)-1:0] phase_err,
    output logic                           locked
);

    localparam int PW  = $clog2(SAMPLE_FREQ);
    localparam int MW  = PW + 1;
    localparam int WCW = (HOLDOFF_BITS < 1) ? 1 : $clog2(HOLDOFF_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_TRACK, S_HOLD} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ph, ph_nxt, ph_inc;
    logic           rxd_q, rxd_q_nxt;
    logic [WCW-1:0] wrap_cnt, wrap_cnt_nxt;
    logic           speed_up_nxt, slow_down_nxt;
    logic [4:0]     diff_amt_nxt;
    logic [PW-1:0]  phase_err_nxt;
    logic           edge_seen, wrap;
    logic [MW-1:0]  err_mag;
    logic [4:0]     err_clip;

    assign ph_inc    = ph + PW'(1);
    assign edge_seen = enb && (rxd != rxd_q);
    assign wrap      = enb && (ph == PW'(SAMPLE_FREQ - 1));

    // Read as two's complement, the edge phase is already the signed error.
    assign err_mag  = ph_inc[PW-1] ? (MW'(SAMPLE_FREQ) - {1'b0, ph_inc}) : {1'b0, ph_inc};
    assign err_clip = (int'(err_mag) > MAX_DIFF) ? 5'(MAX_DIFF) : 5'(err_mag);

    always_comb begin
        state_nxt     = state;
        ph_nxt        = ph;
        rxd_q_nxt     = enb ? rxd : rxd_q;
        wrap_cnt_nxt  = wrap_cnt;
        speed_up_nxt  = 1'b0;
        slow_down_nxt = 1'b0;
        diff_amt_nxt  = diff_amt;
        phase_err_nxt = phase_err;
        if (!lock_en) begin
            state_nxt     = S_IDLE;
            ph_nxt        = '0;
            wrap_cnt_nxt  = '0;
            diff_amt_nxt  = '0;
            phase_err_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ph_nxt    = '0;
                    state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (edge_seen) begin
                        ph_nxt    = '0;
                        state_nxt = S_TRACK;
                    end else if (enb) begin
                        ph_nxt = ph_inc;
                    end
                end
                S_TRACK: begin
                    if (enb) ph_nxt = ph_inc;
                    if (edge_seen) begin
                        phase_err_nxt = ph_inc;
                        if (int'(err_mag) > DEADBAND) begin
                            slow_down_nxt = ~ph_inc[PW-1];
                            speed_up_nxt  = ph_inc[PW-1];
                            diff_amt_nxt  = err_clip;
                            wrap_cnt_nxt  = WCW'(HOLDOFF_BITS);
                            state_nxt     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (enb) ph_nxt = ph_inc;
                    if (wrap_cnt == '0) begin
                        state_nxt = S_TRACK;
                    end else if (wrap) begin
                        wrap_cnt_nxt = wrap_cnt - WCW'(1);
                        if (wrap_cnt == WCW'(1)) state_nxt = S_TRACK;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph        <= '0;
            rxd_q     <= 1'b1;
            wrap_cnt  <= '0;
            speed_up  <= 1'b0;
            slow_down <= 1'b0;
            diff_amt  <= '0;
            phase_err <= '0;
        end else begin
            ph        <= ph_nxt;
            rxd_q     <= rxd_q_nxt;
            wrap_cnt  <= wrap_cnt_nxt;
            speed_up  <= speed_up_nxt;
            slow_down <= slow_down_nxt;
            diff_amt  <= diff_amt_nxt;
            phase_err <= phase_err_nxt;
        end
    end

    assign locked = (state == S_TRACK) || (state == S_HOLD);

endmodule

// File: tb/tb_edge_phase_tracker.sv
// Bench for edge_phase_tracker: directed edge-phase table, corner sequences and
// randomized traffic against a tick-count reference model.
module tb_edge_phase_tracker;

    localparam int SF   = 16;
    localparam int MAXD = 5;
    localparam int DB   = 1;
    localparam int HOLD = 1;

    logic       clk = 1'b0;
    logic       reset, enb, rxd, lock_en;
    logic       speed_up, slow_down, locked;
    logic [4:0] diff_amt;
    logic [3:0] phase_err;

    edge_phase_tracker #(
        .SAMPLE_FREQ(SF), .MAX_DIFF(MAXD), .DEADBAND(DB), .HOLDOFF_BITS(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .enb(enb), .rxd(rxd), .lock_en(lock_en),
        .speed_up(speed_up), .slow_down(slow_down), .diff_amt(diff_amt),
        .phase_err(phase_err), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ticks counted from the acquisition edge; holdoff is an absolute tick limit.
    int m_mode;
    int m_tick;
    int m_hold_end;
    bit m_rxd;
    int x_su, x_sd, x_diff, x_perr;

    function void model_reset();
        m_mode = 0; m_tick = 0; m_hold_end = 0; m_rxd = 1'b1;
        x_su = 0; x_sd = 0; x_diff = 0; x_perr = 0;
    endfunction

    function void model_step(input bit e_n, input bit r, input bit l);
        bit edge_v;
        int p, e, mag;
        edge_v = e_n && (r != m_rxd);
        if (e_n) m_rxd = r;
        x_su = 0;
        x_sd = 0;
        if (!l) begin
            m_mode = 0; x_diff = 0; x_perr = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (e_n) begin
            m_tick++;
            if (m_mode == 1) begin
                if (edge_v) begin
                    m_mode = 2; m_tick = 0; m_hold_end = -1;
                end
            end else if (edge_v && m_tick > m_hold_end) begin
                p   = m_tick % SF;
                e   = (p < SF / 2) ? p : p - SF;
                mag = (e < 0) ? -e : e;
                x_perr = e;
                if (mag > DB) begin
                    if (e > 0) x_sd = 1; else x_su = 1;
                    x_diff     = (mag > MAXD) ? MAXD : mag;
                    m_hold_end = (m_tick / SF + HOLD) * SF;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit e_n, input bit r, input bit l);
        enb = e_n; rxd = r; lock_en = l;
        @(posedge clk);
        #1;
        if (!reset) model_reset();
        else        model_step(e_n, r, l);
    endtask

    task automatic chk_out(input string tag, input int su, input int sd, input int df,
                           input int pe, input int lk);
        chk({tag, ".speed_up"},  int'(speed_up),  su);
        chk({tag, ".slow_down"}, int'(slow_down), sd);
        chk({tag, ".diff_amt"},  int'(diff_amt),  df);
        chk({tag, ".phase_err"}, int'($signed(phase_err)), pe);
        chk({tag, ".locked"},    int'(locked),    lk);
    endtask

    typedef struct {
        int adv;
        bit lk;
        int su;
        int sd;
        int diff;
        int perr;
        int lck;
    } vec_t;

    vec_t vt[14];
    bit   cur_rxd;
    bit   lk;
    bit   pe_q;
    bit   e_r;

    initial begin
        // adv = enb ticks from the previous edge to this one (p = running tick count mod 16)
        vt[0]  = '{16, 1'b1, 0, 0, 0,  0, 1};
        vt[1]  = '{3,  1'b1, 0, 1, 3,  3, 1};
        vt[2]  = '{23, 1'b1, 1, 0, 5, -6, 1};
        vt[3]  = '{14, 1'b1, 1, 0, 5, -8, 1};
        vt[4]  = '{9,  1'b1, 0, 0, 5,  1, 1};
        vt[5]  = '{14, 1'b1, 0, 0, 5, -1, 1};
        vt[6]  = '{3,  1'b1, 0, 1, 2,  2, 1};
        vt[7]  = '{2,  1'b1, 0, 0, 2,  2, 1};
        vt[8]  = '{16, 1'b1, 0, 1, 4,  4, 1};
        vt[9]  = '{12, 1'b1, 0, 0, 4,  4, 1};
        vt[10] = '{5,  1'b1, 0, 1, 5,  5, 1};
        vt[11] = '{23, 1'b1, 1, 0, 4, -4, 1};
        vt[12] = '{11, 1'b1, 0, 1, 5,  7, 1};
        vt[13] = '{14, 1'b0, 0, 0, 0,  0, 0};

        reset = 1'b0; enb = 1'b0; rxd = 1'b1; lock_en = 1'b0;
        model_reset();
        cur_rxd = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cur_rxd = ~cur_rxd;
            step(i[0], cur_rxd, 1'b1);
        end
        chk_out("reset", 0, 0, 0, 0, 0);

        reset = 1'b1;
        cur_rxd = 1'b1;
        step(1'b0, cur_rxd, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cur_rxd = ~cur_rxd;
            step(1'b1, cur_rxd, 1'b0);
            chk_out("disabled_edge", 0, 0, 0, 0, 0);
            step(1'b0, cur_rxd, 1'b0);
        end

        step(1'b0, cur_rxd, 1'b1);
        chk("acq_pre.locked", int'(locked), 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, cur_rxd, 1'b1);
            step(1'b0, cur_rxd, 1'b1);
        end
        cur_rxd = 1'b0;
        step(1'b1, cur_rxd, 1'b1);
        chk_out("acquire", 0, 0, 0, 0, 1);
        step(1'b0, cur_rxd, 1'b1);

        for (int i = 0; i < 14; i++) begin
            for (int k = 1; k < vt[i].adv; k++) begin
                step(1'b1, cur_rxd, 1'b1);
                step(1'b0, cur_rxd, 1'b1);
            end
            cur_rxd = ~cur_rxd;
            step(1'b1, cur_rxd, vt[i].lk);
            chk_out($sformatf("vec%0d", i), vt[i].su, vt[i].sd, vt[i].diff, vt[i].perr, vt[i].lck);
            step(1'b0, cur_rxd, vt[i].lk);
            chk($sformatf("vec%0d.pulse_end", i), int'(speed_up | slow_down), 0);
        end

        // Re-enable after the disable row: one clk in IDLE, then acquire again.
        step(1'b0, cur_rxd, 1'b1);
        chk("reen_idle.locked", int'(locked), 0);
        cur_rxd = ~cur_rxd;
        step(1'b1, cur_rxd, 1'b1);
        chk_out("reacquire", 0, 0, 0, 0, 1);
        step(1'b0, cur_rxd, 1'b1);
        for (int k = 1; k < 3; k++) begin
            step(1'b1, cur_rxd, 1'b1);
            step(1'b0, cur_rxd, 1'b1);
        end
        cur_rxd = ~cur_rxd;
        step(1'b1, cur_rxd, 1'b1);
        chk_out("pre_reset_pulse", 0, 1, 3, 3, 1);
        #2 reset = 1'b0;
        #1;
        chk_out("midpulse_reset", 0, 0, 0, 0, 0);
        model_reset();
        step(1'b0, cur_rxd, 1'b1);
        reset = 1'b1;

        lk = 1'b1;
        pe_q = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            e_r = !pe_q && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) cur_rxd = ~cur_rxd;
            if (lk && $urandom_range(0, 499) == 0)       lk = 1'b0;
            else if (!lk && $urandom_range(0, 5) == 0)  lk = 1'b1;
            step(e_r, cur_rxd, lk);
            pe_q = e_r;
            chk_out("rand", x_su, x_sd, x_diff, x_perr, (m_mode == 2) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_phase_tracker.md
# edge_phase_tracker

Tracks the phase of received-data transitions against the 16x sample tick produced by the variable-rate sampler. It sits directly upstream of that sampler. It measures how early or late each rxd edge lands relative to the local bit boundary and issues single-cycle `speed_up` / `slow_down` requests with a magnitude on `diff_amt`, closing the receiver's clock-recovery loop. It also reports the last measured phase error and a lock indication.

## Interface
- `SAMPLE_FREQ`, 16: enb ticks per bit; power of two, ≥ 8.
- `MAX_DIFF`, 5: clip value for `diff_amt`; the sampler accepts 1..5.
- `DEADBAND`, 1: |error| ≤ DEADBAND produces no request.
- `HOLDOFF_BITS`, 1: bit periods (phase wraps) ignored after each request.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enb`  in  1  sample tick from the sampler; one clk wide, never on consecutive clks.
- `rxd`  in  1  synchronized serial receive data; idle high.
- `lock_en`  in  1  tracking enable; low forces IDLE.
- `speed_up`  out  1  one-clk pulse: raise the sample rate.
- `slow_down`  out  1  one-clk pulse: lower the sample rate.
- `diff_amt`  out  5  request magnitude, 1..MAX_DIFF; held between requests.
- `phase_err`  out  PW=$clog2(SAMPLE_FREQ)  signed last measured error (two's complement).
- `locked`  out  1  high in TRACK or HOLD.

## Operation
- Phase counter `ph` is PW bits wide. It updates only on enb ticks: `ph <= ph+1`, wrapping at SAMPLE_FREQ. Nothing changes on non-enb clocks.
- `rxd_q` samples rxd on each enb tick. An edge is `rxd != rxd_q` at an enb tick.
- Edge phase is `p = ph+1 mod SAMPLE_FREQ`, i.e. the value ph takes at that tick.
- Error calculation:
  - p in 1..SF/2-1 gives e = +p (late edge, local rate too high).
  - p in SF/2..SF-1 gives e = p-SF (early edge).
  - p = 0 gives e = 0.
- States:
  - IDLE: ph=0, outputs quiet. Go to ACQUIRE when lock_en=1.
  - ACQUIRE: wait for the first edge. On that edge, load ph=0 instead of incrementing. No request, no phase_err update. Go to TRACK.
  - TRACK: on each edge, `phase_err <= e`.
    - If |e| > DEADBAND: pulse slow_down when e>0, speed_up when e<0. Set `diff_amt = min(|e|, MAX_DIFF)`, load the wrap counter with HOLDOFF_BITS, and go to HOLD.
    - Otherwise stay in TRACK with no pulse.
  - HOLD: edges are ignored. Each enb tick where ph wraps to 0 decrements the wrap counter. At 0, go back to TRACK.
- lock_en=0 forces IDLE from any state on the next clk. It wins over a simultaneous edge (no pulse). On that transition, phase_err and diff_amt are cleared and ph=0.
- speed_up and slow_down are never high together and never high on consecutive clocks.

## Timing
- Reset (reset=0, async) sets:
  - state=IDLE, ph=0, rxd_q=1, wrap counter=0.
  - speed_up=0, slow_down=0, diff_amt=0, phase_err=0, locked=0.
- Edge latency: an edge sampled on the enb-high clk T produces the request pulse, diff_amt and phase_err on clk T+1. The pulse lasts exactly clk T+1.
- locked rises on the clk after the acquisition edge and falls on the clk after lock_en goes low.
- HOLD lasts from T+1 until the HOLDOFF_BITS-th wrap. An edge on the same tick that ends HOLD is ignored.
- Reset asserted mid-pulse ends the pulse immediately (asynchronous).

## Test plan
- Reset: assert reset=0 for 3 clks with rxd toggling → all outputs 0, locked=0. After release with lock_en=0, rxd edges → no pulses.
- Acquire: lock_en=1, first rxd fall at an arbitrary ph → locked=1 next clk, no pulse. The next edge exactly 16 ticks later → phase_err=0, no pulse.
- Late edge: in TRACK, edge at p=3 → slow_down for one clk at T+1, diff_amt=3, phase_err=+3, then HOLD for one wrap.
- Early edge with clip: edge at p=10 → speed_up, phase_err=-6, diff_amt=5. Edge at p=8 → phase_err=-8, diff_amt=5.
- Deadband and holdoff: edges at p=1 and p=15 → no pulse, phase_err=+1 then -1. After a request, an edge at p=4 within the same bit → ignored; the edge at p=4 after the wrap → slow_down, diff_amt=4.
- Disable: lock_en falls on the same clk an edge is sampled at p=5 → no pulse, locked=0, phase_err=0, state IDLE. Re-enabling lock_en re-enters ACQUIRE.
